// File: rtl/imm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imm_pkg : shared widths, immediate type and select encodings
// Rev 1.0
// ----------------------------------------------------------------------------
package imm_pkg;

  localparam int CIN_WIDTH_DEF = 11;
  localparam int SIN_WIDTH_DEF = 5;
  localparam int IMM_WIDTH_DEF = 16;

  typedef logic signed [IMM_WIDTH_DEF-1:0] imm_t;

  localparam logic IMM_SEL_SIN = 1'b0;
  localparam logic IMM_SEL_CIN = 1'b1;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_extend_shift.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imm_extend_shift : extends cin (signed) or sin (unsigned) and scales by 2
// Rev 1.0
// ----------------------------------------------------------------------------
module imm_extend_shift
  import imm_pkg::*;
#(
  parameter int CIN_WIDTH = CIN_WIDTH_DEF,
  parameter int SIN_WIDTH = SIN_WIDTH_DEF,
  parameter int IMM_WIDTH = IMM_WIDTH_DEF
) (
  input  logic [CIN_WIDTH-1:0] i_cin,
  input  logic [SIN_WIDTH-1:0] i_sin,
  input  logic                 i_select,
  input  logic                 i_double,
  output logic [IMM_WIDTH-1:0] o_imm
);

  logic [IMM_WIDTH-1:0] w_cin_ext;
  logic [IMM_WIDTH-1:0] w_sin_ext;

  // Shifts act on the widened value; the extra headroom bit keeps the sign.
  assign w_cin_ext = {{(IMM_WIDTH-CIN_WIDTH){i_cin[CIN_WIDTH-1]}}, i_cin};
  assign w_sin_ext = {{(IMM_WIDTH-SIN_WIDTH){1'b0}}, i_sin};

  always_comb begin
    o_imm = w_sin_ext << 1;
    if (i_select == IMM_SEL_CIN) begin
      o_imm = i_double ? (w_cin_ext << 1) : w_cin_ext;
    end
  end

endmodule : imm_extend_shift
`default_nettype wire

// File: rtl/immediate_generator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// immediate_generator : registered immediate extension for the datapath
// Rev 1.0
// ----------------------------------------------------------------------------
module immediate_generator
  import imm_pkg::*;
#(
  parameter int CIN_WIDTH = CIN_WIDTH_DEF,
  parameter int SIN_WIDTH = SIN_WIDTH_DEF,
  parameter int IMM_WIDTH = IMM_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CIN_WIDTH-1:0]        cin,
  input  logic [SIN_WIDTH-1:0]        sin,
  input  logic                        Select,
  input  logic                        Double,
  output logic signed [IMM_WIDTH-1:0] imm
);

  generate
    if ((IMM_WIDTH < CIN_WIDTH + 1) || (IMM_WIDTH < SIN_WIDTH + 1)) begin : g_bad_width
      $error("immediate_generator: IMM_WIDTH must exceed CIN_WIDTH and SIN_WIDTH by at least 1");
    end
  endgenerate

  logic [IMM_WIDTH-1:0] imm_d;
  logic [IMM_WIDTH-1:0] imm_q;

  imm_extend_shift #(
    .CIN_WIDTH (CIN_WIDTH),
    .SIN_WIDTH (SIN_WIDTH),
    .IMM_WIDTH (IMM_WIDTH)
  ) u_ext (
    .i_cin    (cin),
    .i_sin    (sin),
    .i_select (Select),
    .i_double (Double),
    .o_imm    (imm_d)
  );

  // No enable: the register reloads every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q <= '0;
    end else begin
      imm_q <= imm_d;
    end
  end

  assign imm = $signed(imm_q);

endmodule : immediate_generator
`default_nettype wire

// File: tb/tb_immediate_generator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_immediate_generator : vector table + random scoreboard for immediate_generator
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_immediate_generator;
  import imm_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [10:0] cin;
  logic [4:0]  sin;
  logic        sel;
  logic        dbl;
  imm_t        imm;

  int n_cmp;
  int n_fail;
  logic signed [15:0] sb[$];

  typedef struct {
    logic               sel;
    logic               dbl;
    logic [10:0]        cin;
    logic [4:0]         sin;
    logic signed [15:0] exp;
  } vec_t;

  vec_t tbl[14];

  immediate_generator dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cin    (cin),
    .sin    (sin),
    .Select (sel),
    .Double (dbl),
    .imm    (imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic signed [15:0] model(input logic s, input logic d,
                                               input logic [10:0] c, input logic [4:0] u);
    int v;
    if (s) begin
      v = int'($signed(c));
      if (d) v = v * 2;
    end else begin
      v = 2 * int'(u);
    end
    return v[15:0];
  endfunction

  task automatic check(input string name, input logic signed [15:0] exp);
    n_cmp++;
    if (imm !== exp) begin
      n_fail++;
      $display("FAIL %s: imm=%0d (0x%h) expected %0d (0x%h) at t=%0t",
               name, imm, imm, exp, exp, $time);
    end
  endtask

  // Drive on the falling edge, then compare one rising edge later.
  task automatic apply(input string name, input logic s, input logic d,
                       input logic [10:0] c, input logic [4:0] u,
                       input logic signed [15:0] exp);
    @(negedge clk);
    sel = s; dbl = d; cin = c; sin = u;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: scoreboard empty, imm=%0d", name, imm);
    end else begin
      check(name, sb.pop_front());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;

    tbl[0]  = '{1'b1, 1'b0, 11'd27,  5'd3,  16'sd27};
    tbl[1]  = '{1'b0, 1'b0, 11'h7FF, 5'd25, 16'sd50};
    tbl[2]  = '{1'b0, 1'b1, 11'h7FF, 5'd25, 16'sd50};
    tbl[3]  = '{1'b1, 1'b1, 11'd27,  5'd31, 16'sd54};
    tbl[4]  = '{1'b1, 1'b0, 11'd27,  5'd31, 16'sd27};
    tbl[5]  = '{1'b1, 1'b1, 11'h7FD, 5'd0,  16'hFFFA};
    tbl[6]  = '{1'b1, 1'b0, 11'h7FD, 5'd0,  16'hFFFD};
    tbl[7]  = '{1'b1, 1'b1, 11'h400, 5'd7,  -16'sd2048};
    tbl[8]  = '{1'b1, 1'b1, 11'h3FF, 5'd7,  16'sd2046};
    tbl[9]  = '{1'b0, 1'b0, 11'h400, 5'd31, 16'sd62};
    tbl[10] = '{1'b1, 1'b0, 11'h400, 5'd1,  -16'sd1024};
    tbl[11] = '{1'b1, 1'b0, 11'h3FF, 5'd1,  16'sd1023};
    tbl[12] = '{1'b0, 1'b1, 11'h3FF, 5'd0,  16'sd0};
    tbl[13] = '{1'b1, 1'b1, 11'h7FF, 5'd31, -16'sd2};

    // Asynchronous reset: imm must clear before any clock edge.
    rst_n = 1'b1; sel = 1'b1; dbl = 1'b1; cin = 11'h155; sin = 5'd19;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 16'sd0);
    repeat (2) begin
      @(posedge clk);
      #1 check("reset_hold", 16'sd0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_no_edge", 16'sd0);

    for (int i = 0; i < 14; i++) begin
      apply($sformatf("vec%0d", i), tbl[i].sel, tbl[i].dbl, tbl[i].cin,
            tbl[i].sin, tbl[i].exp);
    end

    // Inputs change every cycle; each output reflects the previous edge's inputs.
    for (int i = 0; i < 40; i++) begin
      logic        s, d;
      logic [10:0] c;
      logic [4:0]  u;
      s = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      c = 11'($urandom);
      u = 5'($urandom);
      apply($sformatf("rand%0d", i), s, d, c, u, model(s, d, c, u));
    end

    // Reset between edges discards the pending value.
    @(negedge clk);
    sel = 1'b1; dbl = 1'b0; cin = 11'd300; sin = 5'd4;
    @(posedge clk);
    #1 check("pre_midreset", 16'sd300);
    #2 rst_n = 1'b0;
    #1 check("midreset_async", 16'sd0);
    sb.delete();
    @(posedge clk);
    #1 check("midreset_hold", 16'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b0; dbl = 1'b0; sin = 5'd17; cin = 11'h7F0;
    #1 check("midreset_release", 16'sd0);
    @(posedge clk);
    #1 check("first_after_release", 16'sd34);

    apply("post_reset_neg", 1'b1, 1'b1, 11'h7F0, 5'd17, -16'sd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_immediate_generator
`default_nettype wire
